// File: rtl/register_file_scoreboard.sv
`timescale 1ns/1ps
// 16x16 register file with per-register busy scoreboard; combinational reads with same-cycle writeback bypass.
// Writes and reservations take effect on the clock edge; there is no backpressure (every request is accepted).
module register_file_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  srcReg1,
  input  logic [3:0]  srcReg2,
  output logic [15:0] srcRegVal1,
  output logic [15:0] srcRegVal2,
  output logic        inuse1,
  output logic        inuse2,
  input  logic [3:0]  nextDestReg,
  input  logic        reserveEn,
  input  logic        wbEn,
  input  logic [3:0]  wbReg,
  input  logic [15:0] wbVal,
  output logic [15:0] busyMask
);

  logic [15:0][15:0] regs;
  logic [15:0]       busy;
  logic              wbLive;
  logic              resLive;
  logic              bypass1;
  logic              bypass2;

  assign wbLive  = wbEn && (wbReg != 4'd0);
  assign resLive = reserveEn && (nextDestReg != 4'd0);

  // Reservation is applied after writeback so a same-register collision leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (wbLive) begin
        regs[wbReg] <= wbVal;
        busy[wbReg] <= 1'b0;
      end
      if (resLive) begin
        busy[nextDestReg] <= 1'b1;
      end
    end
  end

  always_comb begin
    bypass1    = rst_n && wbLive && (wbReg == srcReg1);
    bypass2    = rst_n && wbLive && (wbReg == srcReg2);
    srcRegVal1 = 16'h0000;
    srcRegVal2 = 16'h0000;
    inuse1     = 1'b0;
    inuse2     = 1'b0;
    // Bypass data must not leak out while reset is held.
    if (rst_n && (srcReg1 != 4'd0)) begin
      srcRegVal1 = bypass1 ? wbVal : regs[srcReg1];
      inuse1     = busy[srcReg1] && !bypass1;
    end
    if (rst_n && (srcReg2 != 4'd0)) begin
      srcRegVal2 = bypass2 ? wbVal : regs[srcReg2];
      inuse2     = busy[srcReg2] && !bypass2;
    end
  end

  assign busyMask = busy & 16'hFFFE;

endmodule

// File: tb/tb_register_file_scoreboard.sv
`timescale 1ns/1ps
// Directed and randomized checks of register_file_scoreboard against an array-based reference model.
module tb_register_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  srcReg1, srcReg2, nextDestReg, wbReg;
  logic [15:0] srcRegVal1, srcRegVal2, wbVal, busyMask;
  logic        inuse1, inuse2, reserveEn, wbEn;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl [16];
  bit          mbusy [16];

  register_file_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .srcReg1(srcReg1), .srcReg2(srcReg2),
    .srcRegVal1(srcRegVal1), .srcRegVal2(srcRegVal2),
    .inuse1(inuse1), .inuse2(inuse2),
    .nextDestReg(nextDestReg), .reserveEn(reserveEn),
    .wbEn(wbEn), .wbReg(wbReg), .wbVal(wbVal),
    .busyMask(busyMask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) begin
      mdl[i]   = 16'h0000;
      mbusy[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] expVal(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (wbEn && wbReg == a) return wbVal;
    return mdl[a];
  endfunction

  function automatic logic [15:0] expInuse(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (wbEn && wbReg == a) return 16'h0000;
    return {15'd0, mbusy[a]};
  endfunction

  function automatic logic [15:0] expMask();
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 1; i < 16; i++) m[i] = mbusy[i];
    return m;
  endfunction

  task automatic checkAll(input string tag);
    check({tag, "/val1"}, srcRegVal1, expVal(srcReg1));
    check({tag, "/val2"}, srcRegVal2, expVal(srcReg2));
    check({tag, "/inuse1"}, {15'd0, inuse1}, expInuse(srcReg1));
    check({tag, "/inuse2"}, {15'd0, inuse2}, expInuse(srcReg2));
    check({tag, "/mask"}, busyMask, expMask());
  endtask

  // Inputs are set just after a negedge; outputs are checked before the posedge, then the model advances.
  task automatic cycle(input string tag);
    #1;
    checkAll(tag);
    @(posedge clk);
    if (wbEn && wbReg != 4'd0) begin
      mdl[wbReg]   = wbVal;
      mbusy[wbReg] = 1'b0;
    end
    if (reserveEn && nextDestReg != 4'd0) mbusy[nextDestReg] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    wbEn = 1'b0; reserveEn = 1'b0;
    wbReg = 4'd0; nextDestReg = 4'd0; wbVal = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0;
    srcReg1 = 4'd0; srcReg2 = 4'd0;
    idle();
    clearModel();

    // Reset held across edges while write/reserve requests are driven: all must be ignored.
    #3;
    wbEn = 1'b1; wbReg = 4'd6; wbVal = 16'hFFFF;
    reserveEn = 1'b1; nextDestReg = 4'd6;
    for (int i = 0; i < 16; i++) begin
      srcReg1 = 4'(i); srcReg2 = 4'(15 - i);
      #1;
      check("rst/val1", srcRegVal1, 16'h0000);
      check("rst/val2", srcRegVal2, 16'h0000);
      check("rst/inuse", {14'd0, inuse1, inuse2}, 16'h0000);
      check("rst/mask", busyMask, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // First edge after release is processed normally.
    reserveEn = 1'b1; nextDestReg = 4'd2;
    cycle("rel");
    idle();
    #1 check("rel/mask", busyMask, 16'h0004);
    wbEn = 1'b1; wbReg = 4'd2; wbVal = 16'h2222;
    cycle("rel/wb");
    idle();

    // Reserve R5, observe in-use, then writeback with bypass.
    reserveEn = 1'b1; nextDestReg = 4'd5;
    cycle("r5/res");
    idle();
    srcReg1 = 4'd5;
    #1;
    check("r5/inuse1", {15'd0, inuse1}, 16'h0001);
    check("r5/mask", busyMask, 16'h0020);
    wbEn = 1'b1; wbReg = 4'd5; wbVal = 16'hBEEF;
    #1;
    check("r5/bypass", srcRegVal1, 16'hBEEF);
    check("r5/bypass_inuse", {15'd0, inuse1}, 16'h0000);
    cycle("r5/wb");
    idle();
    #1;
    check("r5/mask_after", busyMask, 16'h0000);
    check("r5/data", srcRegVal1, 16'hBEEF);

    // Same-cycle reserve and writeback to R7: data lands, busy stays set.
    reserveEn = 1'b1; nextDestReg = 4'd7;
    wbEn = 1'b1; wbReg = 4'd7; wbVal = 16'h1234;
    cycle("r7/both");
    idle();
    srcReg1 = 4'd7;
    #1;
    check("r7/data", srcRegVal1, 16'h1234);
    check("r7/busy", {15'd0, busyMask[7]}, 16'h0001);
    check("r7/inuse1", {15'd0, inuse1}, 16'h0001);
    wbEn = 1'b1; wbReg = 4'd7; wbVal = 16'h7777;
    cycle("r7/clr");
    idle();

    // R0 is hardwired to zero and never reservable.
    wbEn = 1'b1; wbReg = 4'd0; wbVal = 16'hFFFF;
    reserveEn = 1'b1; nextDestReg = 4'd0;
    srcReg1 = 4'd0; srcReg2 = 4'd0;
    cycle("r0/req");
    idle();
    #1;
    check("r0/val1", srcRegVal1, 16'h0000);
    check("r0/mask0", {15'd0, busyMask[0]}, 16'h0000);

    // R4 = 0x00AA and busy, then both ports read R4 during its writeback.
    wbEn = 1'b1; wbReg = 4'd4; wbVal = 16'h00AA;
    reserveEn = 1'b1; nextDestReg = 4'd4;
    cycle("r4/setup");
    idle();
    srcReg1 = 4'd4; srcReg2 = 4'd4;
    #1;
    check("r4/pre_val", srcRegVal2, 16'h00AA);
    wbEn = 1'b1; wbReg = 4'd4; wbVal = 16'h5555;
    #1;
    check("r4/val1", srcRegVal1, 16'h5555);
    check("r4/val2", srcRegVal2, 16'h5555);
    check("r4/inuse", {14'd0, inuse1, inuse2}, 16'h0000);
    cycle("r4/wb");
    idle();

    // Reserve R3 and R9 with live data, then assert reset mid-cycle.
    wbEn = 1'b1; wbReg = 4'd3; wbVal = 16'h3333;
    reserveEn = 1'b1; nextDestReg = 4'd3;
    cycle("rr/r3");
    wbEn = 1'b1; wbReg = 4'd9; wbVal = 16'h9999;
    reserveEn = 1'b1; nextDestReg = 4'd9;
    cycle("rr/r9");
    idle();
    srcReg1 = 4'd3; srcReg2 = 4'd9;
    #1;
    check("rr/pre_mask", busyMask, 16'h0208);
    #1 rst_n = 1'b0;
    #1;
    check("rr/mask", busyMask, 16'h0000);
    check("rr/val3", srcRegVal1, 16'h0000);
    check("rr/val9", srcRegVal2, 16'h0000);
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      srcReg1 = 4'(i); srcReg2 = 4'(i ^ 5);
      cycle("rr/idle");
    end

    // Randomized traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      wbEn        = 1'($urandom_range(0, 1));
      reserveEn   = 1'($urandom_range(0, 1));
      wbReg       = 4'($urandom_range(0, 15));
      nextDestReg = ($urandom_range(0, 3) == 0) ? wbReg : 4'($urandom_range(0, 15));
      wbVal       = 16'($urandom);
      srcReg1     = ($urandom_range(0, 3) == 0) ? wbReg : 4'($urandom_range(0, 15));
      srcReg2     = ($urandom_range(0, 3) == 0) ? srcReg1 : 4'($urandom_range(0, 15));
      cycle("rnd");
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- srcReg1  in  4  read address, port 1 (from decode).
- srcReg2  in  4  read address, port 2 (from decode).
- srcRegVal1  out  16  read data, port 1.
- srcRegVal2  out  16  read data, port 2.
- inuse1  out  1  register at srcReg1 awaits a pending write.
- inuse2  out  1  register at srcReg2 awaits a pending write.
- nextDestReg  in  4  destination register being reserved by decode.
- reserveEn  in  1  qualifies nextDestReg; marks it in use.
- wbEn  in  1  writeback valid (from execute).
- wbReg  in  4  writeback register index.
- wbVal  in  16  writeback data.
- busyMask  out  16  per-register in-use bits; bit i = R[i].

Function
REQ-002 Storage SHALL be 16 registers of 16 bits (R0..R15) plus a 16-bit busy vector.
REQ-003 R0 SHALL always read 0x0000 with inuse 0; writes to R0 SHALL be discarded; reserving R0 SHALL NOT set busy[0].
REQ-004 Reads SHALL be combinational (zero latency) from srcReg1/srcReg2.
REQ-005 Write bypass: when wbEn=1 and wbReg equals a nonzero read address, that port SHALL return wbVal in the same cycle.
REQ-006 inuseN SHALL equal busy[srcRegN] AND NOT (wbEn AND wbReg==srcRegN), forced to 0 for address 0.
REQ-007 On posedge with wbEn=1 and wbReg!=0: R[wbReg] <= wbVal; busy[wbReg] <= 0, except as REQ-009.
REQ-008 On posedge with reserveEn=1 and nextDestReg!=0: busy[nextDestReg] <= 1.
REQ-009 Reserve and writeback to the same register in one cycle: data SHALL be written AND busy SHALL end up 1 (the new reservation wins).
REQ-010 Reserve and writeback to different registers in one cycle: both updates SHALL take effect independently.
REQ-011 Reserving an already-busy register (WAW) SHALL leave the bit at 1; the next writeback to it SHALL clear it; there SHALL be no per-register count.
REQ-012 Writeback to a non-busy register SHALL update data and leave busy at 0, with no error.
REQ-013 Both read ports SHALL operate independently, including when srcReg1 == srcReg2.
REQ-014 busyMask SHALL reflect the registered busy vector (no bypass), with bit 0 always 0.
REQ-015 Reads and inuse SHALL reflect only writebacks of the current cycle, never a same-cycle reservation.

Reset
REQ-016 rst_n=0 SHALL asynchronously clear R1..R15 to 0x0000 and busy to 0, independent of clk.
REQ-017 While rst_n=0, srcRegVal1/2 SHALL read 0x0000 and inuse1/2 and busyMask SHALL be 0; wbEn and reserveEn SHALL be ignored.
REQ-018 Reset asserted while a reservation is outstanding SHALL discard it; after release every register SHALL be idle.
REQ-019 The first posedge after rst_n rises SHALL process reserveEn/wbEn normally.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Reset, then read all 16 addresses on both ports -> all 0x0000, inuse 0, busyMask 0x0000.
- reserveEn=1, nextDestReg=5; next cycle srcReg1=5 -> inuse1=1, busyMask=0x0020; then wbEn=1, wbReg=5, wbVal=0xBEEF same cycle as read -> srcRegVal1=0xBEEF, inuse1=0; next cycle busyMask=0x0000, R5=0xBEEF.
- Same cycle: reserveEn=1, nextDestReg=7, wbEn=1, wbReg=7, wbVal=0x1234 -> after edge R7=0x1234, busy[7]=1.
- wbEn=1, wbReg=0, wbVal=0xFFFF; reserveEn=1, nextDestReg=0 -> R0 reads 0x0000, busyMask bit0 = 0.
- Reserve R3 and R9, assert rst_n=0 between clock edges -> busyMask immediately 0x0000, R3/R9 read 0x0000.
- srcReg1=srcReg2=4 with R4=0x00AA busy, wbEn=1, wbReg=4, wbVal=0x5555 -> both ports 0x5555, inuse1=inuse2=0.
